// File: rtl/mem_access_unit.sv
// Load/store unit between the EX/MEM stage and a single-ported data memory.
// Latches one access at a time, issues a lane-aligned memory request, waits
// for the acknowledge (or a timeout) and returns an extended load result.
//
// Handshake: an access transfers on a rising edge where ReqValid && ReqReady;
// ReqReady is high only in IDLE. The memory side holds DmemReq and its
// address/lane/data signals stable until DmemAck is sampled high. RespValid
// is a single-cycle pulse, and LoadData/ExcMisalign/ExcBus are meaningful only
// while it is high (they read 0 otherwise).
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        MemWrite,
  input  logic [2:0]  AccType,
  input  logic [31:0] Addr,
  input  logic [31:0] StoreData,
  output logic        DmemReq,
  output logic [3:0]  DmemWe,
  output logic [31:0] DmemAddr,
  output logic [31:0] DmemWData,
  input  logic        DmemAck,
  input  logic [31:0] DmemRData,
  output logic        RespValid,
  output logic [31:0] LoadData,
  output logic        ExcMisalign,
  output logic        ExcBus,
  output logic        StallReq,
  output logic [1:0]  dbg_state
);

  // Counter only needs to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic           we_q;
  logic [2:0]     type_q;
  logic [31:0]    addr_q;
  logic [31:0]    sdata_q;
  logic [CW-1:0]  wait_q;
  logic [31:0]    ldata_q;
  logic           mis_q;
  logic           bus_q;

  logic           accept;
  logic           mis_in;
  logic           timeout_hit;
  logic [7:0]     rd_byte;
  logic [15:0]    rd_half;
  logic [31:0]    load_ext;
  logic [3:0]     lanes;
  logic [31:0]    lane_data;

  assign accept      = (state == IDLE) && ReqValid;
  assign timeout_hit = (wait_q == CW'(TIMEOUT - 1));

  // Alignment check on the incoming request: half needs Addr[0]=0, word needs Addr[1:0]=0.
  always_comb begin
    mis_in = 1'b0;
    case (AccType[1:0])
      2'b00:   mis_in = 1'b0;
      2'b01:   mis_in = Addr[0];
      default: mis_in = (Addr[1:0] != 2'b00);
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; an ack in the timeout cycle still counts as completion.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ReqValid) state_nxt = mis_in ? RESP : ACCESS;
      end
      ACCESS: begin
        if (DmemAck || timeout_hit) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read-data selection and sign/zero extension from the latched address and type.
  always_comb begin
    rd_byte  = 8'h00;
    rd_half  = addr_q[1] ? DmemRData[31:16] : DmemRData[15:0];
    load_ext = DmemRData;
    case (addr_q[1:0])
      2'd0:    rd_byte = DmemRData[7:0];
      2'd1:    rd_byte = DmemRData[15:8];
      2'd2:    rd_byte = DmemRData[23:16];
      default: rd_byte = DmemRData[31:24];
    endcase
    case (type_q)
      3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_ext = {24'h000000, rd_byte};
      3'b101:  load_ext = {16'h0000, rd_half};
      default: load_ext = DmemRData;
    endcase
  end

  // Store lane enables and replicated store data.
  always_comb begin
    lanes     = 4'b1111;
    lane_data = sdata_q;
    case (type_q[1:0])
      2'b00: begin
        lane_data = {4{sdata_q[7:0]}};
        case (addr_q[1:0])
          2'd0:    lanes = 4'b0001;
          2'd1:    lanes = 4'b0010;
          2'd2:    lanes = 4'b0100;
          default: lanes = 4'b1000;
        endcase
      end
      2'b01: begin
        lane_data = {2{sdata_q[15:0]}};
        lanes     = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        lanes     = 4'b1111;
        lane_data = sdata_q;
      end
    endcase
  end

  // Request latch, wait counter and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      type_q  <= 3'b000;
      addr_q  <= 32'h0;
      sdata_q <= 32'h0;
      wait_q  <= '0;
      ldata_q <= 32'h0;
      mis_q   <= 1'b0;
      bus_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= MemWrite;
      type_q  <= AccType;
      addr_q  <= Addr;
      sdata_q <= StoreData;
      wait_q  <= '0;
      ldata_q <= 32'h0;
      mis_q   <= mis_in;
      bus_q   <= 1'b0;
    end else if (state == ACCESS) begin
      if (DmemAck) begin
        ldata_q <= we_q ? 32'h0 : load_ext;
        bus_q   <= 1'b0;
      end else if (timeout_hit) begin
        ldata_q <= 32'h0;
        bus_q   <= 1'b1;
      end else begin
        wait_q  <= wait_q + CW'(1);
      end
    end
  end

  // Outputs decoded from state; memory-side signals are zero outside ACCESS.
  always_comb begin
    ReqReady    = (state == IDLE);
    StallReq    = (state != IDLE);
    DmemReq     = (state == ACCESS);
    DmemAddr    = (state == ACCESS) ? {addr_q[31:2], 2'b00} : 32'h0;
    DmemWe      = ((state == ACCESS) && we_q) ? lanes : 4'b0000;
    DmemWData   = ((state == ACCESS) && we_q) ? lane_data : 32'h0;
    RespValid   = (state == RESP);
    LoadData    = (state == RESP) ? ldata_q : 32'h0;
    ExcMisalign = (state == RESP) && mis_q;
    ExcBus      = (state == RESP) && bus_q;
    dbg_state   = state;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized accesses
// checked against an arithmetic reference model of the load/store rules.
module tb_mem_access_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ReqValid;
  logic        ReqReady;
  logic        MemWrite;
  logic [2:0]  AccType;
  logic [31:0] Addr;
  logic [31:0] StoreData;
  logic        DmemReq;
  logic [3:0]  DmemWe;
  logic [31:0] DmemAddr;
  logic [31:0] DmemWData;
  logic        DmemAck;
  logic [31:0] DmemRData;
  logic        RespValid;
  logic [31:0] LoadData;
  logic        ExcMisalign;
  logic        ExcBus;
  logic        StallReq;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .MemWrite(MemWrite), .AccType(AccType), .Addr(Addr), .StoreData(StoreData),
    .DmemReq(DmemReq), .DmemWe(DmemWe), .DmemAddr(DmemAddr), .DmemWData(DmemWData),
    .DmemAck(DmemAck), .DmemRData(DmemRData), .RespValid(RespValid), .LoadData(LoadData),
    .ExcMisalign(ExcMisalign), .ExcBus(ExcBus), .StallReq(StallReq), .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic model_misaligned(input logic [2:0] ty, input logic [31:0] a);
    int unsigned bytes;
    bytes = 1 << ty[1:0];
    return (a % bytes) != 0;
  endfunction

  function automatic logic [3:0] model_lanes(input logic [2:0] ty, input logic [31:0] a);
    int unsigned bytes, first;
    bytes = 1 << ty[1:0];
    first = a % 4;
    return 4'(((1 << bytes) - 1) << first);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] ty, input logic [31:0] d);
    if (ty[1:0] == 2'b00) return (d % 256) * 32'h0101_0101;
    if (ty[1:0] == 2'b01) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] ty, input logic [31:0] a,
                                             input logic [31:0] w);
    int unsigned bytes, v;
    bytes = 1 << ty[1:0];
    if (bytes == 4) return w;
    v = (w >> (8 * (a % 4))) % (1 << (8 * bytes));
    if (ty[2] == 1'b0 && v >= (1 << (8 * bytes - 1))) v = v + (32'hFFFF_FFFF << (8 * bytes));
    return v;
  endfunction

  // ---------------- driver: one complete access ----------------
  // ack_at: ACCESS cycle index (0-based) where DmemAck is raised; -1 = never.
  task automatic run_access(input string tag, input logic wr, input logic [2:0] ty,
                            input logic [31:0] a, input logic [31:0] sd,
                            input logic [31:0] rd, input int ack_at);
    logic        mis, acked;
    logic [31:0] exp_ld;
    int          req_cycles;
    mis = model_misaligned(ty, a);
    acked = 1'b0;
    req_cycles = 0;
    n_checks++;
    if ({ReqReady, RespValid, StallReq} !== 3'b100) begin
      n_errors++;
      $display("FAIL %s idle: ready/resp/stall=%b want 100", tag, {ReqReady, RespValid, StallReq});
    end
    ReqValid  = 1'b1;
    MemWrite  = wr;
    AccType   = ty;
    Addr      = a;
    StoreData = sd;
    DmemAck   = 1'($urandom_range(0, 1));
    DmemRData = $urandom;
    step();
    ReqValid  = 1'b0;
    MemWrite  = 1'($urandom_range(0, 1));
    AccType   = 3'($urandom);
    Addr      = $urandom;
    StoreData = $urandom;
    DmemAck   = 1'b0;
    if (!mis) begin
      for (int c = 0; c < TIMEOUT && !acked; c++) begin
        n_checks++;
        if ({DmemReq, DmemWe, DmemAddr, DmemWData, RespValid, ReqReady, StallReq} !==
            {1'b1, wr ? model_lanes(ty, a) : 4'b0000, a & 32'hFFFF_FFFC,
             wr ? model_wdata(ty, sd) : 32'h0, 1'b0, 1'b0, 1'b1}) begin
          n_errors++;
          $display("FAIL %s access c%0d: req=%b we=%b addr=%h wd=%h resp=%b rdy=%b want we=%b addr=%h wd=%h",
                   tag, c, DmemReq, DmemWe, DmemAddr, DmemWData, RespValid, ReqReady,
                   wr ? model_lanes(ty, a) : 4'b0000, a & 32'hFFFF_FFFC, wr ? model_wdata(ty, sd) : 32'h0);
        end
        req_cycles++;
        if (c == ack_at) begin
          DmemAck = 1'b1;
          DmemRData = rd;
          acked = 1'b1;
        end else begin
          DmemAck = 1'b0;
          DmemRData = $urandom;
        end
        step();
        DmemAck = 1'b0;
        DmemRData = $urandom;
      end
    end
    exp_ld = (mis || !acked || wr) ? 32'h0 : model_load(ty, a, rd);
    n_checks++;
    if ({RespValid, ExcMisalign, ExcBus, LoadData, DmemReq, ReqReady, StallReq} !==
        {1'b1, mis, !mis && !acked, exp_ld, 1'b0, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL %s resp after %0d req cycles: rv=%b mis=%b bus=%b ld=%h req=%b rdy=%b want mis=%b bus=%b ld=%h",
               tag, req_cycles, RespValid, ExcMisalign, ExcBus, LoadData, DmemReq, ReqReady,
               mis, !mis && !acked, exp_ld);
    end
    step();
    n_checks++;
    if ({ReqReady, RespValid, ExcMisalign, ExcBus, LoadData, DmemReq} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0}) begin
      n_errors++;
      $display("FAIL %s post: rdy=%b rv=%b mis=%b bus=%b ld=%h req=%b want rdy=1 others 0",
               tag, ReqReady, RespValid, ExcMisalign, ExcBus, LoadData, DmemReq);
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    ReqValid = 1'b0; MemWrite = 1'b0; AccType = 3'b000; Addr = 32'h0; StoreData = 32'h0;
    DmemAck = 1'b0; DmemRData = 32'h0;
    step();
    step();
    rst_n = 1'b1;
    n_checks++;
    if ({ReqReady, DmemReq, DmemWe, DmemAddr, DmemWData, RespValid, LoadData, ExcMisalign, ExcBus, StallReq} !==
        {1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset: rdy=%b req=%b we=%b addr=%h wd=%h rv=%b ld=%h mis=%b bus=%b stall=%b want rdy=1 rest 0",
               ReqReady, DmemReq, DmemWe, DmemAddr, DmemWData, RespValid, LoadData, ExcMisalign, ExcBus, StallReq);
    end
  endtask

  task automatic test_directed();
    run_access("lb_0x103", 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0);
    n_checks++;
    if (model_load(3'b000, 32'h103, 32'h80FF_1234) !== 32'hFFFF_FF80) begin
      n_errors++;
      $display("FAIL model_lb: got %h want ffffff80", model_load(3'b000, 32'h103, 32'h80FF_1234));
    end
    run_access("sh_0x202", 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 0);
    n_checks++;
    if ({model_lanes(3'b001, 32'h202), model_wdata(3'b001, 32'hABCD)} !== {4'b1100, 32'hABCD_ABCD}) begin
      n_errors++;
      $display("FAIL model_sh: got %b %h want 1100 abcdabcd",
               model_lanes(3'b001, 32'h202), model_wdata(3'b001, 32'hABCD));
    end
    run_access("lw_mis_0x006", 1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'h1234_5678, 0);
    run_access("lh_mis", 1'b0, 3'b001, 32'h0000_0011, 32'h0, 32'h1234_5678, 0);
    run_access("sw_mis", 1'b1, 3'b010, 32'h0000_0012, 32'hDEAD_BEEF, 32'h0, 0);
    run_access("lw_timeout", 1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'h0, -1);
    run_access("lw_ack_last", 1'b0, 3'b010, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, TIMEOUT - 1);
    run_access("lhu_hi", 1'b0, 3'b101, 32'h0000_0082, 32'h0, 32'h9ABC_1234, 2);
    run_access("lh_hi", 1'b0, 3'b001, 32'h0000_0082, 32'h0, 32'h9ABC_1234, 1);
    run_access("sb_lane3", 1'b1, 3'b000, 32'h0000_0093, 32'h0000_00A5, 32'h0, 0);
  endtask

  task automatic test_reset_mid_access();
    ReqValid = 1'b1; MemWrite = 1'b0; AccType = 3'b101; Addr = 32'h0000_0010;
    step();
    ReqValid = 1'b0;
    n_checks++;
    if (DmemReq !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_mid c1: req=%b want 1", DmemReq);
    end
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    DmemAck = 1'b1;
    DmemRData = 32'h5555_AAAA;
    n_checks++;
    if ({DmemReq, RespValid, ReqReady, StallReq} !== 4'b0010) begin
      n_errors++;
      $display("FAIL rst_mid after: req=%b rv=%b rdy=%b stall=%b want 0010", DmemReq, RespValid, ReqReady, StallReq);
    end
    step();
    DmemAck = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({DmemReq, RespValid, ReqReady, LoadData} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
        n_errors++;
        $display("FAIL rst_mid late_ack %0d: req=%b rv=%b rdy=%b ld=%h want 0 0 1 0",
                 i, DmemReq, RespValid, ReqReady, LoadData);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] sb_data, mem_word;
    int          cyc;
    sb_data  = $urandom;
    mem_word = $urandom;
    ReqValid = 1'b1; MemWrite = 1'b1; AccType = 3'b000; Addr = 32'h0000_0301; StoreData = sb_data;
    step();
    n_checks++;
    if ({DmemReq, DmemWe, ReqReady} !== {1'b1, 4'b0010, 1'b0}) begin
      n_errors++;
      $display("FAIL b2b sb access: req=%b we=%b rdy=%b want 1 0010 0", DmemReq, DmemWe, ReqReady);
    end
    DmemAck = 1'b1;
    mem_word[15:8] = DmemWData[15:8];
    step();
    DmemAck = 1'b0;
    MemWrite = 1'b0; AccType = 3'b100;
    n_checks++;
    if ({RespValid, ReqReady, DmemReq} !== 3'b100) begin
      n_errors++;
      $display("FAIL b2b sb resp: rv=%b rdy=%b req=%b want 100", RespValid, ReqReady, DmemReq);
    end
    step();
    n_checks++;
    if ({ReqReady, DmemReq, RespValid} !== 3'b100) begin
      n_errors++;
      $display("FAIL b2b gap: rdy=%b req=%b rv=%b want 100", ReqReady, DmemReq, RespValid);
    end
    step();
    ReqValid = 1'b0;
    cyc = 0;
    while (DmemReq !== 1'b1 && cyc < 4) begin
      step();
      cyc++;
    end
    n_checks++;
    if ({DmemReq, DmemWe, cyc} !== {1'b1, 4'b0000, 32'd0}) begin
      n_errors++;
      $display("FAIL b2b lbu access: req=%b we=%b wait=%0d want 1 0000 0", DmemReq, DmemWe, cyc);
    end
    DmemAck = 1'b1;
    DmemRData = mem_word;
    step();
    DmemAck = 1'b0;
    n_checks++;
    if ({RespValid, LoadData} !== {1'b1, 24'h0, sb_data[7:0]}) begin
      n_errors++;
      $display("FAIL b2b lbu resp: rv=%b ld=%h want 1 %h", RespValid, LoadData, {24'h0, sb_data[7:0]});
    end
    step();
  endtask

  task automatic test_random();
    logic [2:0] ty;
    logic       wr;
    int         ack_at, pick;
    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom_range(0, 1));
      if (wr) ty = 3'($urandom_range(0, 2));
      else begin
        pick = $urandom_range(0, 4);
        ty = (pick < 3) ? 3'(pick) : 3'(pick + 1);
      end
      pick = $urandom_range(0, 9);
      ack_at = (pick == 0) ? -1 : (pick == 1) ? TIMEOUT - 1 : $urandom_range(0, 4);
      run_access($sformatf("rand%0d", i), wr, ty, $urandom, $urandom, $urandom, ack_at);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT, default 16, sets the number of cycles to wait for DmemAck before signalling a bus error.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 ReqValid  in  1  EX/MEM stage presents an access.
REQ-005 ReqReady  out  1  unit accepts an access this cycle.
REQ-006 MemWrite  in  1  1 = store, 0 = load.
REQ-007 AccType  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; for stores the low 2 bits give the size (00 byte, 01 half, 10 word).
REQ-008 Addr  in  32  byte address (the ALU result).
REQ-009 StoreData  in  32  store operand, right-aligned.
REQ-010 DmemReq  out  1  memory request strobe.
REQ-011 DmemWe  out  4  byte-lane write enables (0000 = read).
REQ-012 DmemAddr  out  32  word address {Addr[31:2],2'b00}.
REQ-013 DmemWData  out  32  lane-shifted store data.
REQ-014 DmemAck  in  1  memory completes the request.
REQ-015 DmemRData  in  32  read word, valid with DmemAck.
REQ-016 RespValid  out  1  one-cycle pulse: access finished.
REQ-017 LoadData  out  32  extended load result, valid with RespValid.
REQ-018 ExcMisalign  out  1  with RespValid: access was misaligned and not performed.
REQ-019 ExcBus  out  1  with RespValid: timeout expired.
REQ-020 StallReq  out  1  high while a request is held in ACCESS or RESP.

Function
REQ-021 FSM states: IDLE, ACCESS, RESP; ReqReady = 1 only in IDLE.
REQ-022 In IDLE with ReqValid = 1, the unit latches MemWrite, AccType, Addr and StoreData.
REQ-023 In that same IDLE cycle, an aligned request moves the FSM to ACCESS.
REQ-024 In that same IDLE cycle, a misaligned request (half with Addr[0]=1, or word with Addr[1:0]!=0) goes straight to RESP with ExcMisalign set, and no DmemReq is issued.
REQ-025 In ACCESS, DmemReq = 1 and DmemAddr, DmemWe and DmemWData are held stable every cycle until DmemAck.
REQ-026 Store byte lanes: a byte enables lane Addr[1:0] with data replicated {4{b}}.
REQ-027 Store half-word lanes: enables lanes 0011 or 1100 selected by Addr[1], with data {2{h}}.
REQ-028 Store word lanes: enables 1111.
REQ-029 On DmemAck in ACCESS, the unit registers the shifted and extended read data and moves to RESP on the next edge.
REQ-030 Loads select the byte or half-word using the latched Addr[1:0]; LB and LH sign-extend, LBU and LHU zero-extend, LW passes the word through.
REQ-031 A wait counter clears on entry to ACCESS and increments each ACCESS cycle without DmemAck.
REQ-032 When the wait counter reaches TIMEOUT-1 without DmemAck, the FSM goes to RESP with ExcBus = 1 and LoadData = 0.
REQ-033 DmemAck on the same cycle as the timeout wins: normal completion, ExcBus = 0.
REQ-034 RESP lasts exactly one cycle with RespValid = 1, then returns to IDLE; a new request is accepted no earlier than the cycle after RESP.
REQ-035 Latency for an aligned access with DmemAck in the first ACCESS cycle is accept edge -> ACCESS -> RESP, so RespValid is high 2 cycles after acceptance.
REQ-036 Latency for a misaligned access: RespValid is high 1 cycle after acceptance.
REQ-037 For stores, LoadData = 0 in RESP.
REQ-038 ExcMisalign and ExcBus are 0 whenever RespValid = 0.
REQ-039 DmemAck outside ACCESS is ignored.
REQ-040 StallReq = (state != IDLE).

Reset
REQ-041 With rst_n = 0 at a clock edge, the FSM enters IDLE, the wait counter and all latched fields clear, and every output is 0 except ReqReady, which is 1 from the first cycle after reset.
REQ-042 Reset asserted mid-ACCESS drops DmemReq on the next edge with no RespValid.
REQ-043 A DmemAck that arrives after such a reset is ignored.

Verification
REQ-044 LB at Addr 0x103, DmemRData 0x80FF_1234, ack in 1st ACCESS cycle -> RespValid 2 cycles after accept, LoadData 0xFFFF_FF80.
REQ-045 SH data 0x0000_ABCD at Addr 0x202 -> DmemAddr 0x200, DmemWe 1100, DmemWData 0xABCD_ABCD, RespValid with LoadData 0.
REQ-046 LW at Addr 0x006 -> no DmemReq, RespValid with ExcMisalign = 1 one cycle after accept.
REQ-047 LW with TIMEOUT = 16 and DmemAck never asserted -> DmemReq high 16 cycles, then RespValid with ExcBus = 1, LoadData 0, then ReqReady = 1.
REQ-048 LHU at Addr 0x10 with ack on cycle 3, rst_n pulsed low in cycle 2 -> IDLE, DmemReq 0, no RespValid, the late ack is ignored.
REQ-049 Back-to-back ReqValid held high for SB then LBU at the same address -> second accepted only after RESP of the first, readback byte zero-extended.
